// File: rtl/npuarc_arct_cti_trig_hs_pkg.sv
// -----------------------------------------------------------------------------
// npuarc_arct_cti_trig_hs_pkg
// Shared definitions for the CTI trigger handshake block: the per-channel
// handshake FSM state encoding and the default pending-counter width.
// -----------------------------------------------------------------------------
package npuarc_arct_cti_trig_hs_pkg;

   // Four-phase handshake FSM states (2-bit encoding, 2'd3 unused)
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_RELEASE = 2'd2
   } hs_state_e;

   // Default pending-counter width; up to 2^CNT_W-1 queued events per channel
   localparam int CTI_CNT_W = 3;

endpackage : npuarc_arct_cti_trig_hs_pkg

// File: rtl/npuarc_arct_cti_trig_chan.sv
// -----------------------------------------------------------------------------
// npuarc_arct_cti_trig_chan
// One trigger channel: rising-edge detect, saturating pending-event counter
// and a four-phase req/ack FSM that replays each event as one handshake.
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   trig_in      trigger level from the CTI pipeline
//   trig_ack     acknowledge from the cross-trigger matrix
//   trig_req     handshake request (registered)
//   trig_pend    registered flag: pending counter non-zero
//   trig_ovf     sticky drop flag        (only with NPUARC_ARCT_CTI_TRIG_OVF_EN)
//   trig_ovf_clr clear for trig_ovf      (only with NPUARC_ARCT_CTI_TRIG_OVF_EN)
//
// Optional feature macro: NPUARC_ARCT_CTI_TRIG_OVF_EN
// -----------------------------------------------------------------------------
module npuarc_arct_cti_trig_chan
   import npuarc_arct_cti_trig_hs_pkg::*;
#(
   parameter int CNT_W = CTI_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trig_in,
   input  logic trig_ack,
`ifdef NPUARC_ARCT_CTI_TRIG_OVF_EN
   input  logic trig_ovf_clr,
   output logic trig_ovf,
`endif
   output logic trig_req,
   output logic trig_pend
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   hs_state_e        state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic             prev_r;
   logic             src_cnt_r, src_cnt_nxt_s;
   logic             req_r, req_nxt_s;
   logic             pend_r;
   logic             evt_s, cnt_nz_s, direct_s, inc_s, dec_s, full_s;

   assign evt_s    = trig_in & ~prev_r;
   assign cnt_nz_s = (cnt_r != CNT_ZERO);
   // An event arriving in IDLE with nothing queued is served directly, never counted
   assign direct_s = (state_r == ST_IDLE) && !cnt_nz_s;
   assign inc_s    = evt_s && !direct_s;
   // Only a handshake that was taken from the counter gives its slot back on ack
   assign dec_s    = (state_r == ST_REQ) && trig_ack && src_cnt_r;
   assign full_s   = (cnt_r == CNT_MAX);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; ack seen in IDLE is deliberately ignored
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cnt_nz_s || evt_s) state_nxt_s = ST_REQ;
            else                   state_nxt_s = ST_IDLE;
         end
         ST_REQ: begin
            if (trig_ack) state_nxt_s = ST_RELEASE;
            else          state_nxt_s = ST_REQ;
         end
         ST_RELEASE: begin
            if (!trig_ack) state_nxt_s = ST_IDLE;
            else           state_nxt_s = ST_RELEASE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output and counter next-value logic
   always_comb begin
      req_nxt_s = (state_nxt_s == ST_REQ);
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_REQ)) begin
         src_cnt_nxt_s = cnt_nz_s;
      end else begin
         src_cnt_nxt_s = src_cnt_r;
      end
      // At saturation an increment without a matching decrement is dropped
      if (inc_s && dec_s) begin
         cnt_nxt_s = cnt_r;
      end else if (inc_s && !full_s) begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end else if (dec_s) begin
         cnt_nxt_s = cnt_r - CNT_ONE;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Edge history, counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_r    <= 1'b0;
         cnt_r     <= CNT_ZERO;
         src_cnt_r <= 1'b0;
         req_r     <= 1'b0;
         pend_r    <= 1'b0;
      end else begin
         prev_r    <= trig_in;
         cnt_r     <= cnt_nxt_s;
         src_cnt_r <= src_cnt_nxt_s;
         req_r     <= req_nxt_s;
         pend_r    <= cnt_nz_s;
      end
   end

   assign trig_req  = req_r;
   assign trig_pend = pend_r;

`ifdef NPUARC_ARCT_CTI_TRIG_OVF_EN
   logic ovf_r;
   logic drop_s;

   assign drop_s = inc_s && !dec_s && full_s;

   // Sticky overflow flag; a drop in the clear cycle keeps the bit set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (drop_s) begin
         ovf_r <= 1'b1;
      end else if (trig_ovf_clr) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign trig_ovf = ovf_r;
`endif

endmodule : npuarc_arct_cti_trig_chan

// File: rtl/npuarc_arct_cti_trig_hs.sv
// -----------------------------------------------------------------------------
// npuarc_arct_cti_trig_hs
// Converts pipelined CTI trigger levels into per-channel four-phase req/ack
// handshakes toward the cross-trigger matrix. Bursts are queued per channel
// and replayed one handshake per event. Channels are independent.
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   trig_in      [WIDTH] trigger levels from the CTI pipeline
//   trig_ack     [WIDTH] acknowledges from the matrix
//   trig_req     [WIDTH] handshake requests
//   trig_pend    [WIDTH] pending-counter non-zero flags
//   trig_ovf     [WIDTH] sticky drop flags   (only with NPUARC_ARCT_CTI_TRIG_OVF_EN)
//   trig_ovf_clr clear all trig_ovf bits     (only with NPUARC_ARCT_CTI_TRIG_OVF_EN)
//   trig_busy    OR of all trig_req and trig_pend
//
// Optional feature macro: NPUARC_ARCT_CTI_TRIG_OVF_EN
// -----------------------------------------------------------------------------
module npuarc_arct_cti_trig_hs
   import npuarc_arct_cti_trig_hs_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = CTI_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] trig_in,
   input  logic [WIDTH-1:0] trig_ack,
   output logic [WIDTH-1:0] trig_req,
   output logic [WIDTH-1:0] trig_pend,
`ifdef NPUARC_ARCT_CTI_TRIG_OVF_EN
   output logic [WIDTH-1:0] trig_ovf,
   input  logic             trig_ovf_clr,
`endif
   output logic             trig_busy
);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      npuarc_arct_cti_trig_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .trig_in      (trig_in[gi]),
         .trig_ack     (trig_ack[gi]),
`ifdef NPUARC_ARCT_CTI_TRIG_OVF_EN
         .trig_ovf_clr (trig_ovf_clr),
         .trig_ovf     (trig_ovf[gi]),
`endif
         .trig_req     (trig_req[gi]),
         .trig_pend    (trig_pend[gi])
      );
   end

   // Combinational from registered req/pend only
   assign trig_busy = |(trig_req | trig_pend);

endmodule : npuarc_arct_cti_trig_hs

// File: tb/tb_npuarc_arct_cti_trig_hs.sv
module tb_npuarc_arct_cti_trig_hs;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] trig_in = 8'h00;
   logic [WIDTH-1:0] trig_ack = 8'h00;
   logic [WIDTH-1:0] trig_req;
   logic [WIDTH-1:0] trig_pend;
   logic             trig_busy;
`ifdef NPUARC_ARCT_CTI_TRIG_OVF_EN
   logic [WIDTH-1:0] trig_ovf;
   logic             trig_ovf_clr = 1'b0;
`endif

   npuarc_arct_cti_trig_hs #(.WIDTH(WIDTH), .CNT_W(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .trig_in      (trig_in),
      .trig_ack     (trig_ack),
      .trig_req     (trig_req),
      .trig_pend    (trig_pend),
`ifdef NPUARC_ARCT_CTI_TRIG_OVF_EN
      .trig_ovf     (trig_ovf),
      .trig_ovf_clr (trig_ovf_clr),
`endif
      .trig_busy    (trig_busy)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int cyc;

   // Cycle number since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Handshake monitor: counts rising edges of each trig_req bit
   bit [WIDTH-1:0] req_q = '0;
   int             hs_cnt [WIDTH];
   always @(negedge clk) begin
      req_q <= trig_req;
      for (int i = 0; i < WIDTH; i++) begin
         if (trig_req[i] && !req_q[i]) hs_cnt[i] <= hs_cnt[i] + 1;
      end
   end

   // Scoreboard of expected handshake counts per channel
   typedef struct {
      int ch;
      int n;
   } sb_t;
   sb_t sb_q[$];
   int  base [WIDTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_open();
      for (int i = 0; i < WIDTH; i++) base[i] = hs_cnt[i];
   endtask

   // Expect n handshakes on ch and none on any other channel
   task automatic sb_push_only(input int ch, input int n);
      sb_t e;
      for (int i = 0; i < WIDTH; i++) begin
         e.ch = i;
         e.n  = (i == ch) ? n : 0;
         sb_q.push_back(e);
      end
   endtask

   task automatic sb_score();
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk($sformatf("hs_ch%0d", e.ch), hs_cnt[e.ch] - base[e.ch], e.n);
      end
   endtask

   task automatic pulse(input int ch);
      trig_in[ch] = 1'b1;
      tick();
      trig_in[ch] = 1'b0;
      tick();
   endtask

   // Auto-acknowledge every request until the block has been quiet for 3 cycles
   task automatic drain(input int budget);
      int quiet = 0;
      for (int k = 0; k < budget && quiet < 3; k++) begin
         trig_ack = trig_req;
         tick();
         if (trig_req == 8'h00 && trig_pend == 8'h00 && trig_ack == 8'h00) quiet++;
         else quiet = 0;
      end
      chk("drain_done", (quiet >= 3) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", {24'd0, trig_req}, 32'd0);
      chk("rst_pend", {24'd0, trig_pend}, 32'd0);
      chk("rst_busy", {31'd0, trig_busy}, 32'd0);
      rst_n = 1'b1;

      // ---------------- isolated event latency ----------------
      sb_open();
      while (cyc < 10) tick();
      chk("lat_c10_req", {31'd0, trig_req[0]}, 32'd0);
      trig_in[0] = 1'b1;
      tick();
      chk("lat_c11_req", {31'd0, trig_req[0]}, 32'd1);
      trig_in[0] = 1'b0;
      while (cyc < 14) tick();
      chk("lat_c14_req", {31'd0, trig_req[0]}, 32'd1);
      trig_ack[0] = 1'b1;
      tick();
      chk("lat_c15_req", {31'd0, trig_req[0]}, 32'd0);
      tick();
      trig_ack[0] = 1'b0;
      tick();
      chk("lat_c17_idle", {30'd0, dut.g_chan[0].u_chan.state_r}, 32'd0);
      chk("lat_c17_cnt", {29'd0, dut.g_chan[0].u_chan.cnt_r}, 32'd0);
      sb_push_only(0, 1);
      repeat (3) tick();
      sb_score();

      // ---------------- three edges on ch3 ----------------
      sb_open();
      repeat (3) pulse(3);
      chk("ch3_req", {31'd0, trig_req[3]}, 32'd1);
      chk("ch3_cnt", {29'd0, dut.g_chan[3].u_chan.cnt_r}, 32'd2);
      chk("ch3_pend", {24'd0, trig_pend}, 32'h08);
      sb_push_only(3, 3);
      drain(100);
      sb_score();
      chk("ch3_pend_end", {24'd0, trig_pend}, 32'd0);
      chk("ch3_busy_end", {31'd0, trig_busy}, 32'd0);

      // ---------------- saturation on ch1 ----------------
      sb_open();
      repeat (10) pulse(1);
      chk("ch1_cnt_sat", {29'd0, dut.g_chan[1].u_chan.cnt_r}, 32'd7);
      chk("ch1_busy", {31'd0, trig_busy}, 32'd1);
`ifdef NPUARC_ARCT_CTI_TRIG_OVF_EN
      chk("ch1_ovf", {24'd0, trig_ovf}, 32'h02);
`endif
      sb_push_only(1, 8);
      drain(200);
      sb_score();
`ifdef NPUARC_ARCT_CTI_TRIG_OVF_EN
      chk("ch1_ovf_sticky", {24'd0, trig_ovf}, 32'h02);
      trig_ovf_clr = 1'b1;
      tick();
      trig_ovf_clr = 1'b0;
      chk("ch1_ovf_clr", {24'd0, trig_ovf}, 32'h00);
`endif

      // ---------------- edge coincident with decrement on ch2 ----------------
      sb_open();
      repeat (3) pulse(2);
      chk("ch2_cnt_pre", {29'd0, dut.g_chan[2].u_chan.cnt_r}, 32'd2);
      trig_ack[2] = 1'b1;
      tick();
      trig_ack[2] = 1'b0;
      k = 0;
      for (int j = 1; j <= 10 && k == 0; j++) begin
         tick();
         if (trig_req[2]) k = j;
      end
      chk("ch2_rearm_lat", k, 32'd2);
      trig_ack[2] = 1'b1;
      trig_in[2]  = 1'b1;
      tick();
      chk("ch2_same_cycle_cnt", {29'd0, dut.g_chan[2].u_chan.cnt_r}, 32'd2);
      trig_in[2]  = 1'b0;
      trig_ack[2] = 1'b0;
      sb_push_only(2, 4);
      drain(100);
      sb_score();

      // ---------------- reset mid-handshake on ch5 ----------------
      sb_open();
      repeat (5) pulse(5);
      chk("ch5_cnt", {29'd0, dut.g_chan[5].u_chan.cnt_r}, 32'd4);
      chk("ch5_req", {31'd0, trig_req[5]}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ch5_rst_req", {31'd0, trig_req[5]}, 32'd0);
      chk("ch5_rst_cnt", {29'd0, dut.g_chan[5].u_chan.cnt_r}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) tick();
      chk("ch5_post_req", {24'd0, trig_req}, 32'd0);
      chk("ch5_post_pend", {24'd0, trig_pend}, 32'd0);
      sb_push_only(5, 1);
      sb_score();

      // ---------------- spurious ack, then all channels at once ----------------
      sb_open();
      trig_ack = 8'hFF;
      repeat (2) tick();
      chk("spur_req", {24'd0, trig_req}, 32'd0);
      chk("spur_busy", {31'd0, trig_busy}, 32'd0);
      chk("spur_state", {30'd0, dut.g_chan[4].u_chan.state_r}, 32'd0);
      trig_ack = 8'h00;
      tick();
      trig_in = 8'hFF;
      tick();
      trig_in = 8'h00;
      chk("all_req", {24'd0, trig_req}, 32'hFF);
      for (int c = 0; c < 60; c++) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (trig_req[i] && c >= 3 * i) trig_ack[i] = 1'b1;
            else if (!trig_req[i])         trig_ack[i] = 1'b0;
         end
         tick();
      end
      trig_ack = 8'h00;
      repeat (2) tick();
      for (int i = 0; i < WIDTH; i++) begin
         sb_t e;
         e.ch = i;
         e.n  = 1;
         sb_q.push_back(e);
      end
      sb_score();
      chk("all_busy_end", {31'd0, trig_busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_npuarc_arct_cti_trig_hs

// File: doc/npuarc_arct_cti_trig_hs.md
Name: npuarc_arct_cti_trig_hs

Overview:
- Consumer of the CTI trigger pipeline output. Turns pipelined trigger levels into per-channel four-phase req/ack handshakes toward the cross-trigger matrix.
- Each channel detects rising edges and queues them in a saturating pending counter.
- Each queued event is replayed as exactly one handshake, so bursts of triggers are not lost while the matrix is slow to acknowledge.

Parameters:
- WIDTH, 8, number of trigger channels; must match the upstream pipeline WIDTH.
- CNT_W, 3, pending-counter width per channel; maximum queued events = 2^CNT_W-1.

Ports:
- clk  input  1  core clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset; async assert, sync deassert handled externally.
- trig_in  input  WIDTH  trigger levels from the CTI pipeline dout; already synchronous to clk.
- trig_req  output  WIDTH  per-channel handshake request.
- trig_ack  input  WIDTH  per-channel acknowledge from the matrix; synchronous to clk.
- trig_pend  output  WIDTH  per-channel flag, high when that channel's pending counter is non-zero.
- trig_busy  output  1  OR of all trig_req and trig_pend.

Behaviour:
- Reset values: trig_req=0, trig_pend=0, trig_busy=0. All counters=0, edge-history register=0, every channel FSM in IDLE.
- Edge detect: evt[i] = trig_in[i] & ~prev[i], with prev registered every cycle.
  - A high level held across reset release therefore produces one event on the first clk after release.
- Per-channel FSM, states IDLE / REQ / RELEASE:
  - IDLE: if cnt!=0 or evt, move to REQ and drive trig_req high on the next cycle.
    - A fresh evt with cnt==0 is forwarded directly. It is never counted and then decremented in the same cycle.
  - REQ: hold trig_req=1 until trig_ack=1. On that cycle, move to RELEASE and decrement cnt if the pending event came from the counter.
  - RELEASE: trig_req=0. Wait for trig_ack=0, then go to IDLE.
  - Rearm latency: after ack falls, trig_req rises again no earlier than 2 cycles later if cnt!=0. IDLE is always visited for one cycle.
- Latency, isolated event: trig_in rises at cycle N, trig_req rises at cycle N+1.
- Counter rules:
  - evt while the channel is not accepting it directly (REQ, RELEASE, or IDLE with cnt!=0): cnt+1.
  - Simultaneous evt and decrement: cnt unchanged.
  - At cnt=2^CNT_W-1, a further evt is dropped and cnt saturates; there is no wrap-around.
- trig_ack high while in IDLE is ignored and must not alter state.
- trig_pend[i] is a registered copy of (cnt[i]!=0), so it lags the counter by 1 cycle. trig_busy is combinational from registered signals.
- Channels are fully independent; no arbitration between them.
- Reset mid-handshake: everything returns to reset values immediately, pending events are discarded, and trig_req drops asynchronously.

Optional Feature:
- Macro NPUARC_ARCT_CTI_TRIG_OVF_EN.
- When defined:
  - Adds output trig_ovf (WIDTH). Bit i is sticky, set on any evt dropped at saturation.
  - Adds input trig_ovf_clr (1). trig_ovf_clr=1 clears all bits on the next cycle; a drop in the same cycle wins, so the bit stays set.
  - trig_ovf resets to 0.
- When undefined: both ports are absent and drops are silent. All other behaviour is identical.

Decomposition:
- Shared package/defines (rtt pkg defines): 2-bit FSM state encodings IDLE=2'd0, REQ=2'd1, RELEASE=2'd2; the default CNT_W constant.
- Sub-module npuarc_arct_cti_trig_chan: one channel covering edge detect, counter, FSM and ovf bit. It is instantiated WIDTH times in a generate loop. The top level holds only the generate loop and the trig_busy OR.

Test Plan:
- Reset, then trig_in[0] 0->1 at cycle 10 → trig_req[0]=1 at cycle 11. With ack raised at cycle 14 and lowered at 16: req=0 from cycle 15, FSM back in IDLE at 17, cnt stays 0.
- Three rising edges on ch3 while ack is held low → one req active, cnt=2, trig_pend[3]=1. Ack cycling → exactly 3 handshakes total, then pend=0 and busy=0.
- CNT_W=3 with 10 edges on ch1 and ack stuck low → cnt saturates at 7. Releasing ack → 8 handshakes (1 active + 7 queued). With OVF_EN, trig_ovf[1]=1 until trig_ovf_clr is pulsed.
- Edge on ch2 in the same cycle as ack-driven decrement with cnt=2 → cnt remains 2.
- rst_n asserted while ch5 is in REQ with cnt=4 → trig_req[5]=0 immediately. After release with trig_in[5] low: no req, pend=0.
- All 8 channels get edges in the same cycle with independent ack timing → each channel completes exactly one handshake with no cross-channel interaction; spurious ack in IDLE has no effect.
